// File: rtl/lsu_store_buffer.sv
// Load/store unit in front of a byte-addressed big-endian data memory.
// Stores are posted to a small FIFO and drained one per cycle; loads read directly unless they overlap a buffered store.
module lsu_store_buffer #(
    parameter int unsigned SB_DEPTH  = 4,
    parameter int unsigned MEM_BYTES = 100
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        LSU_req_valid,
    output logic        LSU_req_ready,
    input  logic        LSU_req_is_store,
    input  logic [1:0]  LSU_req_length,
    input  logic        LSU_req_signed,
    input  logic [31:0] LSU_req_address,
    input  logic [31:0] LSU_req_wdata,
    input  logic        SB_drain_hold,
    output logic        LSU_rsp_valid,
    output logic [31:0] LSU_rsp_data,
    output logic        LSU_rsp_error,
    output logic        LSU_sb_empty,
    output logic [31:0] MEM_read_address,
    output logic [1:0]  MEM_read_length,
    output logic        MEM_read_signed,
    input  logic [31:0] MEM_read_data,
    output logic [31:0] MEM_write_address,
    output logic [1:0]  MEM_write_length,
    output logic [31:0] MEM_write_data
);
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      sb_addr_q [SB_DEPTH];
    logic [1:0]       sb_len_q  [SB_DEPTH];
    logic [31:0]      sb_data_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [31:0]      rsp_data_q, rsp_data_d;

    logic [32:0]      req_lo, req_end, slot_lo, slot_hi;
    logic [PTR_W-1:0] slot_off;
    logic             req_err, overlap, accept, push, pop, load_acc;

    function automatic logic [32:0] nbytes(input logic [1:0] len);
        case (len)
            2'b01:   return 33'd1;
            2'b10:   return 33'd2;
            2'b11:   return 33'd4;
            default: return 33'd0;
        endcase
    endfunction

    // Request decode, range check and overlap search over the live FIFO slots.
    always_comb begin
        req_lo   = {1'b0, LSU_req_address};
        req_end  = req_lo + nbytes(LSU_req_length);
        req_err  = (LSU_req_length == 2'b00) || (req_end > 33'(MEM_BYTES));
        overlap  = 1'b0;
        slot_off = '0;
        slot_lo  = '0;
        slot_hi  = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            slot_off = PTR_W'(i) - head_q;
            slot_lo  = {1'b0, sb_addr_q[PTR_W'(i)]};
            slot_hi  = slot_lo + nbytes(sb_len_q[PTR_W'(i)]);
            if ((CNT_W'(slot_off) < count_q) && (slot_lo < req_end) && (req_lo < slot_hi)) begin
                overlap = 1'b1;
            end
        end
    end

    always_comb begin
        LSU_req_ready = 1'b0;
        if (!SYS_reset) begin
            if (req_err)               LSU_req_ready = 1'b1;
            else if (LSU_req_is_store) LSU_req_ready = (count_q < CNT_W'(SB_DEPTH));
            else                       LSU_req_ready = !overlap;
        end
        accept   = LSU_req_valid && LSU_req_ready;
        push     = accept && LSU_req_is_store && !req_err;
        load_acc = accept && !LSU_req_is_store && !req_err;
        pop      = !SYS_reset && (count_q != '0) && !SB_drain_hold;
    end

    // Memory ports: read port follows an accepted load, write port follows the draining head.
    always_comb begin
        MEM_read_address  = '0;
        MEM_read_length   = 2'b00;
        MEM_read_signed   = 1'b0;
        MEM_write_address = '0;
        MEM_write_length  = 2'b00;
        MEM_write_data    = '0;
        if (load_acc) begin
            MEM_read_address = LSU_req_address;
            MEM_read_length  = LSU_req_length;
            MEM_read_signed  = LSU_req_signed;
        end
        if (pop) begin
            MEM_write_address = sb_addr_q[head_q];
            MEM_write_length  = sb_len_q[head_q];
            MEM_write_data    = sb_data_q[head_q];
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rsp_valid_d = accept;
        rsp_error_d = accept && req_err;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    assign rsp_data_d = load_acc ? MEM_read_data : 32'h0;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by head/count.
    always_ff @(posedge SYS_clk) begin
        if (push) begin
            sb_addr_q[tail_q] <= LSU_req_address;
            sb_len_q[tail_q]  <= LSU_req_length;
            sb_data_q[tail_q] <= LSU_req_wdata;
        end
    end

    assign LSU_rsp_valid = rsp_valid_q;
    assign LSU_rsp_error = rsp_error_q;
    assign LSU_rsp_data  = rsp_data_q;
    assign LSU_sb_empty  = (count_q == '0);
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_lsu_store_buffer;
    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned MEM_BYTES = 100;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_is_store, req_signed, hold;
    logic [1:0]  req_len, rd_len, wr_len;
    logic [31:0] req_addr, req_wdata, rsp_data, rd_addr, rd_data, wr_addr, wr_data;
    logic        rsp_valid, rsp_error, sb_empty, rd_signed;

    always #5 clk = ~clk;

    lsu_store_buffer #(.SB_DEPTH(SB_DEPTH), .MEM_BYTES(MEM_BYTES)) dut (
        .SYS_clk(clk), .SYS_reset(rst),
        .LSU_req_valid(req_valid), .LSU_req_ready(req_ready), .LSU_req_is_store(req_is_store),
        .LSU_req_length(req_len), .LSU_req_signed(req_signed), .LSU_req_address(req_addr),
        .LSU_req_wdata(req_wdata), .SB_drain_hold(hold),
        .LSU_rsp_valid(rsp_valid), .LSU_rsp_data(rsp_data), .LSU_rsp_error(rsp_error),
        .LSU_sb_empty(sb_empty),
        .MEM_read_address(rd_addr), .MEM_read_length(rd_len), .MEM_read_signed(rd_signed),
        .MEM_read_data(rd_data),
        .MEM_write_address(wr_addr), .MEM_write_length(wr_len), .MEM_write_data(wr_data)
    );

    // Environment data memory (written only by the DUT) and the model's own memory image.
    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic [7:0] rb      [4];
    int unsigned wn;

    always_comb begin
        for (int k = 0; k < 4; k++)
            rb[k] = (rd_addr + 32'(k) < 32'(MEM_BYTES)) ? mem[7'(rd_addr + 32'(k))] : 8'h00;
    end

    always_comb begin
        case (rd_len)
            2'b01:   rd_data = rd_signed ? {{24{rb[0][7]}}, rb[0]} : {24'h0, rb[0]};
            2'b10:   rd_data = rd_signed ? {{16{rb[0][7]}}, rb[0], rb[1]} : {16'h0, rb[0], rb[1]};
            2'b11:   rd_data = {rb[0], rb[1], rb[2], rb[3]};
            default: rd_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (wr_len != 2'b00) begin
            wn = (wr_len == 2'b01) ? 1 : (wr_len == 2'b10) ? 2 : 4;
            for (int unsigned k = 0; k < 4; k++)
                if (k < wn && wr_addr + k < MEM_BYTES)
                    mem[7'(wr_addr + k)] <= wr_data[8*(wn-1-k) +: 8];
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } st_t;

    st_t sbq[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nb(input logic [1:0] len);
        return (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : (len == 2'd3) ? 4 : 0;
    endfunction

    // Big-endian value of n bytes, sign-extended arithmetically when requested.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] len, input logic sg);
        longint unsigned v = 0;
        int unsigned n = nb(len);
        for (int unsigned k = 0; k < n; k++) v = v * 256 + 64'(ref_mem[7'(a + k)]);
        if (sg && v >= (64'd1 << (8*n-1))) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    // One clock of traffic: predict ready/ports, update the model, then check the response.
    task automatic cycle(input logic v, input logic st, input logic [1:0] len, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic h, output logic acc);
        int unsigned n;
        logic err, rdy, ovl, drain, ld;
        logic exp_rv, exp_re;
        logic [31:0] exp_rd;
        st_t e;
        req_valid = v; req_is_store = st; req_len = len; req_signed = sg;
        req_addr = a; req_wdata = d; hold = h;
        n   = nb(len);
        err = (len == 2'b00) || (longint'(a) + longint'(n) > longint'(MEM_BYTES));
        ovl = 1'b0;
        foreach (sbq[i]) begin
            if (longint'(sbq[i].addr) < longint'(a) + longint'(n) &&
                longint'(a) < longint'(sbq[i].addr) + longint'(nb(sbq[i].len)))
                ovl = 1'b1;
        end
        rdy   = err || (st ? (sbq.size() < SB_DEPTH) : !ovl);
        acc   = v && rdy;
        ld    = acc && !st && !err;
        drain = (sbq.size() > 0) && !h;
        e     = drain ? sbq[0] : '0;
        @(negedge clk);
        chk("ready", 32'(req_ready), 32'(rdy));
        chk("sb_empty", 32'(sb_empty), 32'(sbq.size() == 0));
        chk("wr_len", 32'(wr_len), 32'(e.len));
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("rd_len", 32'(rd_len), ld ? 32'(len) : 32'h0);
        chk("rd_addr", rd_addr, ld ? a : 32'h0);
        chk("rd_signed", 32'(rd_signed), ld ? 32'(sg) : 32'h0);
        exp_rv = acc;
        exp_re = acc && err;
        exp_rd = ld ? ref_load(a, len, sg) : 32'h0;
        if (drain) begin
            for (int unsigned k = 0; k < nb(e.len); k++)
                ref_mem[7'(e.addr + k)] = 8'(e.data >> (8*(nb(e.len)-1-k)));
            void'(sbq.pop_front());
        end
        if (acc && st && !err) sbq.push_back('{addr: a, len: len, data: d});
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_error", 32'(rsp_error), 32'(exp_re));
        chk("rsp_data", rsp_data, exp_rd);
    endtask

    // Retry a request until the model accepts it, within a cycle budget.
    task automatic issue(input logic st, input logic [1:0] len, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic h);
        logic acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, st, len, sg, a, d, h, acc);
        chk("accepted_within_budget", 32'(acc), 32'h1);
    endtask

    task automatic idle(input int cycles, input logic h);
        logic acc;
        repeat (cycles) cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, h, acc);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; req_valid = 1'b1; req_is_store = 1'b1; req_len = 2'b11;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; hold = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            chk("ready_in_reset", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 1'b0;
        sbq.delete();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_error", 32'(rsp_error), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_sb_empty", 32'(sb_empty), 32'h1);
        chk("rst_wr_len", 32'(wr_len), 32'h0);
        chk("rst_rd_len", 32'(rd_len), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; hold = 1'b0;
        do_reset(2);

        // Word store then loads that must wait for the drain.
        issue(1'b1, 2'b11, 1'b0, 32'd8, 32'h11223344, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'd8, 32'h0, 1'b0);
        chk("t1_byte_signed", rsp_data, 32'h00000011);
        issue(1'b0, 2'b10, 1'b0, 32'd10, 32'h0, 1'b0);
        chk("t1_half_unsigned", rsp_data, 32'h00003344);

        // Half store with sign extension on load.
        issue(1'b1, 2'b10, 1'b0, 32'd20, 32'h00008001, 1'b0);
        issue(1'b0, 2'b10, 1'b1, 32'd20, 32'h0, 1'b0);
        chk("t2_half_signed", rsp_data, 32'hFFFF8001);
        issue(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 1'b0);
        chk("t2_half_unsigned", rsp_data, 32'h00008001);

        // Fill under hold, fifth store stalls, load proceeds, then drain in order.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 2'b11, 1'b0, 32'(4*i), $urandom, 1'b1, acc);
            chk("t3_store_accepted", 32'(rsp_valid), 32'h1);
        end
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 32'd16, 32'hCAFEF00D, 1'b1, acc);
        chk("t3_full_no_rsp", 32'(rsp_valid), 32'h0);
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 32'd40, 32'h0, 1'b1, acc);
        chk("t3_load_rsp", 32'(rsp_valid), 32'h1);
        idle(4, 1'b0);
        chk("t3_empty_after_drain", 32'(sb_empty), 32'h1);
        issue(1'b1, 2'b11, 1'b0, 32'd16, 32'hCAFEF00D, 1'b0);
        idle(2, 1'b0);

        // Range and length errors, plus legal accesses at the top of memory.
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 32'd97, 32'h0, 1'b0, acc);
        chk("t4_load97_err", 32'(rsp_error), 32'h1);
        chk("t4_load97_data", rsp_data, 32'h0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 32'hFFFFFFFE, 32'h12345678, 1'b0, acc);
        chk("t4_wrap_store_err", 32'(rsp_error), 32'h1);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 1'b0, acc);
        chk("t4_len0_err", 32'(rsp_error), 32'h1);
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 32'd96, 32'h0, 1'b0, acc);
        chk("t4_load96_ok", 32'(rsp_error), 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'd99, 32'h000000A5, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 32'd100, 32'h0, 1'b0, acc);
        chk("t4_store100_err", 32'(rsp_error), 32'h1);
        issue(1'b0, 2'b01, 1'b0, 32'd99, 32'h0, 1'b0);
        chk("t4_byte99", rsp_data, 32'h000000A5);

        // Reset discards buffered stores.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 2'b11, 1'b0, 32'(60 + 4*i), $urandom, 1'b1, acc);
        do_reset(1);
        idle(4, 1'b0);

        // Random traffic with overlaps, errors, hold and occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int unsigned r = $urandom_range(0, 99);
            if (r < 75)      a = 32'($urandom_range(0, 40));
            else if (r < 92) a = 32'($urandom_range(90, 110));
            else             a = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), 1'($urandom), a,
                      $urandom, ($urandom_range(0, 9) < 3), acc);
            end
        end
        idle(6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
